// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the core's load/store (MEM stage) interface. It accepts
// one word-addressed LW/SW request at a time and inserts WAIT_CYCLES wait
// states before the access. It then returns exactly one response strobe that
// carries either the load data or a store acknowledge, plus an address-error
// flag.
//
// Parameters:
//   DEPTH        number of 32-bit words; legal word indices 0..DEPTH-1
//   WAIT_CYCLES  wait states between acceptance and access (0..15)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_write   1 = store, 0 = load
//   req_addr    32-bit word index (not a byte address)
//   req_wdata   store data
//   req_ready   high while idle; a request is taken when valid && ready
//   resp_valid  one-cycle response strobe
//   resp_rdata  load data; 0 for stores and out-of-range accesses
//   resp_err    address out of range, qualified by resp_valid
//   busy        request in flight (inverse of req_ready)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_q,     state_d;
    logic [3:0]  waitCnt_q,   waitCnt_d;
    logic [31:0] reqAddr_q,   reqAddr_d;
    logic        reqWrite_q,  reqWrite_d;
    logic [31:0] reqWdata_q,  reqWdata_d;
    logic        respValid_q, respValid_d;
    logic [31:0] respRdata_q, respRdata_d;
    logic        respErr_q,   respErr_d;

    logic [31:0] mem [DEPTH];

    logic             accessNow;
    logic             inRange;
    logic [IDX_W-1:0] memIdx;
    logic [31:0]      memRdata;

    // The range check uses the full 32-bit address so that large indices can
    // never alias onto a legal word through truncation. The low index bits are
    // only used once the access is known to be in range.
    assign inRange   = (reqAddr_q < DEPTH_W);
    assign memIdx    = reqAddr_q[IDX_W-1:0];
    assign memRdata  = mem[memIdx];
    assign accessNow = (state_q == WAIT) && (waitCnt_q == 4'd0);

    // Next-state logic. Request fields are captured only on acceptance, so
    // input activity while a request is in flight has no effect. The response
    // strobe defaults low, which makes it last exactly one cycle. Data and
    // error hold their values between responses.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        reqAddr_d   = reqAddr_q;
        reqWrite_d  = reqWrite_q;
        reqWdata_d  = reqWdata_q;
        respValid_d = 1'b0;
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = WAIT;
                    waitCnt_d  = WAIT_INIT;
                    reqAddr_d  = req_addr;
                    reqWrite_d = req_write;
                    reqWdata_d = req_wdata;
                end
            end
            WAIT: begin
                if (waitCnt_q != 4'd0) begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end else begin
                    state_d     = IDLE;
                    respValid_d = 1'b1;
                    respErr_d   = !inRange;
                    respRdata_d = (!reqWrite_q && inRange) ? memRdata : 32'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered response. Reset has priority over
    // acceptance, so a request presented while rst is high is not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            waitCnt_q   <= 4'd0;
            reqAddr_q   <= 32'd0;
            reqWrite_q  <= 1'b0;
            reqWdata_q  <= 32'd0;
            respValid_q <= 1'b0;
            respRdata_q <= 32'd0;
            respErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            reqAddr_q   <= reqAddr_d;
            reqWrite_q  <= reqWrite_d;
            reqWdata_q  <= reqWdata_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
        end
    end

    // Storage array. It has no reset of its own. A store commits only on its
    // access edge, and only when reset is low on that edge, so a reset that
    // lands on the access edge still drops the store. Out-of-range stores are
    // suppressed.
    always_ff @(posedge clk) begin
        if (!rst && accessNow && reqWrite_q && inRange) begin
            mem[memIdx] <= reqWdata_q;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q == WAIT);
    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Scoreboard bench for dmem_responder. Three responders share the request
// bus and reset, and each has its own req_valid:
//   instance 0: WAIT_CYCLES = 2
//   instance 1: WAIT_CYCLES = 1
//   instance 2: WAIT_CYCLES = 0
// Only one instance is driven at a time. Each accepted request pushes its
// hand-computed response (instance, response cycle, data, error) onto a queue.
// A monitor pops an entry whenever any instance raises resp_valid.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid  [3];
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        reqReady  [3];
    logic        respValid [3];
    logic [31:0] respRdata [3];
    logic        respErr   [3];
    logic        busyOut   [3];

    exp_t expQ[$];
    int   edgeCount = 0;
    int   testsRun  = 0;
    int   failCount = 0;

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Counts rising edges. At a falling edge, edgeCount identifies the rising
    // edge that just happened.
    always @(posedge clk) edgeCount <= edgeCount + 1;

    for (genvar g = 0; g < 3; g++) begin : gDut
        dmem_responder #(
            .DEPTH       (1024),
            .WAIT_CYCLES (2 - g)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (reqValid[g]),
            .req_write  (reqWrite),
            .req_addr   (reqAddr),
            .req_wdata  (reqWdata),
            .req_ready  (reqReady[g]),
            .resp_valid (respValid[g]),
            .resp_rdata (respRdata[g]),
            .resp_err   (respErr[g]),
            .busy       (busyOut[g])
        );
    end

    function automatic int waitOf(input int inst);
        return 2 - inst;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one request at the current falling edge and waits for the
    // responder to become ready. The acceptance edge is the next rising edge.
    // The task returns at the falling edge right after acceptance. The
    // expected response is queued unless the request is meant to be killed
    // by reset.
    task automatic applyStimulus(input int inst, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input bit expectResp, input bit holdValid,
                                 input string name, output int acceptEdge);
        exp_t e;
        reqWrite       = wr;
        reqAddr        = addr;
        reqWdata       = wdata;
        reqValid[inst] = 1'b1;
        acceptEdge     = -1;
        for (int k = 0; k < 40; k++) begin
            if (reqReady[inst] === 1'b1) begin
                acceptEdge = edgeCount + 1;
                break;
            end
            @(negedge clk);
        end
        if (acceptEdge < 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL %s accept: got no acceptance within 40 cycles, expected acceptance", name);
            reqValid[inst] = 1'b0;
            return;
        end
        if (expectResp) begin
            e.inst  = inst;
            e.cyc   = acceptEdge + 1 + waitOf(inst);
            e.rdata = expRdata;
            e.err   = expErr;
            e.name  = name;
            expQ.push_back(e);
        end
        @(negedge clk);
        if (!holdValid) reqValid[inst] = 1'b0;
    endtask

    // Waits, within a bound, until every queued response has been seen.
    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain pending responses", 32'(expQ.size()), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: on every response strobe, pops the oldest expectation and
    // checks instance, cycle of arrival, data, error, and that req_ready is
    // already back high. A strobe with nothing queued is a spurious response.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (respValid[i] === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL spurious response: instance %0d at edge %0d got resp_valid=1, expected 0",
                             i, edgeCount);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, " instance"}, 32'(i), 32'(e.inst));
                    checkOutput({e.name, " cycle"}, 32'(edgeCount), 32'(e.cyc));
                    checkOutput({e.name, " rdata"}, respRdata[i], e.rdata);
                    checkOutput({e.name, " err"}, {31'd0, respErr[i]}, {31'd0, e.err});
                    checkOutput({e.name, " ready"}, {31'd0, reqReady[i]}, 32'd1);
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int a0, a1, a2, a3;
        int acc [4];
        rst      = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 32'd0;
        reqWdata = 32'd0;
        for (int i = 0; i < 3; i++) reqValid[i] = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            checkOutput("reset req_ready", {31'd0, reqReady[i]}, 32'd1);
            checkOutput("reset busy", {31'd0, busyOut[i]}, 32'd0);
            checkOutput("reset resp_valid", {31'd0, respValid[i]}, 32'd0);
            checkOutput("reset resp_rdata", respRdata[i], 32'd0);
            checkOutput("reset resp_err", {31'd0, respErr[i]}, 32'd0);
        end
        rst = 1'b0;

        // Store then load on the two-wait-state responder, plus preloads.
        applyStimulus(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1, 0, "sw5", a0);
        applyStimulus(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 1, 0, "lw5", a0);
        applyStimulus(0, 1'b1, 32'd1023, 32'h3FF03FF0, 32'd0, 1'b0, 1, 0, "sw1023", a0);
        applyStimulus(0, 1'b1, 32'd0, 32'h00001234, 32'd0, 1'b0, 1, 0, "sw0", a0);
        applyStimulus(0, 1'b1, 32'd7, 32'h00000011, 32'd0, 1'b0, 1, 0, "sw7", a0);
        applyStimulus(0, 1'b1, 32'd3, 32'h00000033, 32'd0, 1'b0, 1, 0, "sw3", a0);
        applyStimulus(0, 1'b1, 32'd4, 32'h00000044, 32'd0, 1'b0, 1, 0, "sw4", a0);

        // Out-of-range accesses. These stores must not alias onto words 0 or
        // 1023.
        applyStimulus(0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, 1, 0, "lw1024", a0);
        applyStimulus(0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1, 0, "swFFFFFFFF", a0);
        applyStimulus(0, 1'b1, 32'd1024, 32'h55, 32'd0, 1'b1, 1, 0, "sw1024", a0);
        applyStimulus(0, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1, 0, "lwFFFFFFFF", a0);
        applyStimulus(0, 1'b0, 32'd1023, 32'd0, 32'h3FF03FF0, 1'b0, 1, 0, "lw1023", a0);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 32'h00001234, 1'b0, 1, 0, "lw0", a0);
        drain();

        // Reset during the wait states drops a pending store.
        applyStimulus(0, 1'b1, 32'd7, 32'h22, 32'd0, 1'b0, 0, 0, "sw7 killed", a0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("ready after mid reset", {31'd0, reqReady[0]}, 32'd1);
        checkOutput("no resp after mid reset", {31'd0, respValid[0]}, 32'd0);
        repeat (5) @(negedge clk);

        // A reset that lands exactly on the access edge also drops the store.
        applyStimulus(0, 1'b1, 32'd7, 32'h33, 32'd0, 1'b0, 0, 0, "sw7 access-edge reset", a0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // A request presented together with reset is not accepted.
        reqValid[0] = 1'b1;
        reqWrite    = 1'b1;
        reqAddr     = 32'd7;
        reqWdata    = 32'h77;
        rst         = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        reqValid[0] = 1'b0;
        checkOutput("request during reset not taken", {31'd0, reqReady[0]}, 32'd1);
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, 32'd7, 32'd0, 32'h11, 1'b0, 1, 0, "lw7 after resets", a0);
        drain();

        // Inputs scrambled while busy are ignored.
        applyStimulus(0, 1'b0, 32'd3, 32'd0, 32'h33, 1'b0, 1, 1, "lw3 scrambled", a0);
        for (int k = 0; k < 20; k++) begin
            if (reqReady[0] === 1'b1) begin
                reqValid[0] = 1'b0;
                break;
            end
            reqAddr  = 32'd4;
            reqWrite = ~reqWrite;
            reqWdata = 32'hBAD0BAD0;
            @(negedge clk);
        end
        reqValid[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'd4, 32'd0, 32'h44, 1'b0, 1, 0, "lw4 unmodified", a0);
        drain();

        // Back-to-back loads with valid held high on the one-wait-state
        // responder.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b1, 32'(k), 32'hA0 + 32'(k), 32'd0, 1'b0, 1, 0, "preload a", a0);
        end
        drain();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b0, 32'(k), 32'd0, 32'hA0 + 32'(k), 1'b0, 1, (k < 3), "b2b lw", acc[k]);
            checkOutput("b2b ready low in wait", {31'd0, reqReady[1]}, 32'd0);
            checkOutput("b2b busy high in wait", {31'd0, busyOut[1]}, 32'd1);
        end
        for (int k = 1; k < 4; k++) begin
            checkOutput("b2b acceptance spacing", 32'(acc[k] - acc[k-1]), 32'd3);
        end
        drain();

        // Zero wait states: one-cycle latency and acceptances two edges apart.
        applyStimulus(2, 1'b1, 32'd9, 32'h99, 32'd0, 1'b0, 1, 0, "sw9", a0);
        drain();
        applyStimulus(2, 1'b0, 32'd9, 32'd0, 32'h99, 1'b0, 1, 1, "lw9 first", a1);
        applyStimulus(2, 1'b0, 32'd9, 32'd0, 32'h99, 1'b0, 1, 0, "lw9 second", a2);
        checkOutput("zero-wait acceptance spacing", 32'(a2 - a1), 32'd2);
        drain();

        // Write-then-read on the zero-wait responder back to back.
        applyStimulus(2, 1'b1, 32'd9, 32'hCAFE0009, 32'd0, 1'b0, 1, 1, "sw9 new", a3);
        applyStimulus(2, 1'b0, 32'd9, 32'd0, 32'hCAFE0009, 1'b0, 1, 0, "lw9 new", a3);
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Word-addressed data-memory responder: the memory-side end of the pipeline's load/store (MEM stage) interface. It accepts one LW/SW request at a time over a valid/ready handshake and inserts a programmable number of wait states. It returns exactly one response per request, carrying read data or write acknowledge plus an address-error flag. It replaces the flat zero-latency data array so the core can be exercised against realistic memory latency.

Parameters:
DEPTH, 1024, number of 32-bit words; legal word indices are 0..DEPTH-1.
WAIT_CYCLES, 1, wait states inserted between acceptance and access; legal range 0..15.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  request present.
req_write  input  1  1 = store (SW), 0 = load (LW).
req_addr  input  32  word index; ALU result, not a byte address.
req_wdata  input  32  store data.
req_ready  output  1  responder can accept; high exactly when the FSM is in IDLE.
resp_valid  output  1  one-cycle response strobe.
resp_rdata  output  32  load data; 0 for stores and errored accesses.
resp_err  output  1  address out of range; qualified by resp_valid.
busy  output  1  request in flight; equals !req_ready.

Behaviour:
- Reset: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0. Memory contents are not reset.
- Acceptance: a request is accepted on a posedge where req_valid && req_ready. addr, write and wdata are latched at that edge. While not in IDLE, request inputs are ignored, however they change.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT on acceptance; counter loaded with WAIT_CYCLES.
  - WAIT with counter != 0: counter decrements by 1 per edge.
  - WAIT with counter == 0: the access executes at that edge, the response registers are loaded, and state returns to IDLE.
- Latency: for acceptance at edge E, the access edge is E+1+WAIT_CYCLES. resp_valid is high for exactly the one cycle after that edge, then clears at the next edge.
- Throughput: req_ready rises in the same cycle resp_valid is high. The earliest next acceptance is edge E+2+WAIT_CYCLES, so back-to-back requests are accepted once every WAIT_CYCLES+2 cycles.
- Read: resp_rdata = mem[addr], resp_err=0.
- Write: mem[addr] <= wdata at the access edge; resp_rdata=0, resp_err=0.
- Write-then-read to the same address: the read returns the new data, because accesses are strictly serialized.
- Out of range (addr >= DEPTH, full 32-bit unsigned compare, no wrap or truncation):
  - resp_err=1 and resp_rdata=0.
  - A store is suppressed and no memory word changes.
- resp_rdata and resp_err hold their last values while resp_valid=0. The bench must only sample them when resp_valid=1.
- Reset mid-operation: the in-flight request is dropped, no response is issued, and a pending store is not committed. Reset on the access edge itself has priority, so that store is also not committed.
- A request arriving in the same cycle as rst=1 is not accepted.

Test Plan:
1. WAIT_CYCLES=2; SW addr 5, data 0xDEADBEEF accepted at edge 10 -> resp_valid high in the cycle after edge 13 (only), resp_err=0, resp_rdata=0. Then LW addr 5 -> resp_rdata=0xDEADBEEF.
2. LW addr 1024 -> resp_err=1, resp_rdata=0. SW addr 0xFFFFFFFF data 0x1 -> resp_err=1; a subsequent LW of addr 1023 and addr 0 returns their prior values unchanged.
3. WAIT_CYCLES=1; req_valid held high with 4 LWs to addrs 0..3 preloaded 0xA0..0xA3 -> accepted at edges E, E+3, E+6, E+9; responses 0xA0..0xA3 in order; req_ready low exactly during WAIT.
4. Addr 7 preloaded 0x11; SW addr 7 data 0x22 with rst pulsed during WAIT -> no resp_valid, req_ready=1 next cycle, and a subsequent LW addr 7 returns 0x11.
5. WAIT_CYCLES=0; LW addr 9 (0x99) accepted at edge E -> resp_valid high after edge E+1, next acceptance possible at edge E+2.
6. Accept LW addr 3, then change req_addr to 4 and toggle req_write while busy -> response is the read of addr 3, and addr 4 is unmodified.
